rf_read_stage: RTL and testbench
================================

// Module: rf_read_stage
// PURPOSE
//  Read side of the 32-entry integer register file. Takes decoded rs1/rs2
//  indices from decode over a valid/ready handshake and selects operands from
//  the flattened register outputs (x0..x31). Forwards a same-cycle write-back
//  and registers the operands for execute with 1-cycle latency. Keeps held
//  operands coherent with write-backs while execute stalls. Supports flush.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   register index width; the file has 2**ADDR_WIDTH entries
//  PC_WIDTH    32  width of the tag carried alongside the operands
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  async reset, active-low (0 = reset)
//  rf_q       in   32*DATA_WIDTH      {Q31,...,Q0}; Qn at [n*DATA_WIDTH +: DATA_WIDTH]
//  wb_en      in   1                  write-back strobe, same cycle as file enable
//  wb_addr    in   ADDR_WIDTH         write-back register index
//  wb_data    in   DATA_WIDTH         write-back data, the file's D input
//  in_valid   in   1                  decode presents rs1/rs2/pc
//  in_ready   out  1                  stage can accept this cycle
//  in_rs1     in   ADDR_WIDTH         source index 1
//  in_rs2     in   ADDR_WIDTH         source index 2
//  in_pc      in   PC_WIDTH           tag passed through unchanged
//  flush      in   1                  discard the held and incoming entry
//  out_valid  out  1                  operands valid to execute
//  out_ready  in   1                  execute consumes this cycle
//  out_rs1    out  DATA_WIDTH         operand 1
//  out_rs2    out  DATA_WIDTH         operand 2
//  out_pc     out  PC_WIDTH           tag of the held entry
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0; out_rs1, out_rs2 and out_pc = 0; stored
//    indices = 0. Reset that lands while an entry is held drops the entry.
//  - in_ready = !out_valid | out_ready. This is combinational. It does not
//    depend on in_valid or flush.
//  - Accept: in_valid & in_ready & !flush. On that edge the stage stores
//    out_valid=1, out_pc=in_pc, the rs indices, and sel(in_rs1)/sel(in_rs2).
//  - sel(r): if r==0, 0. Else if wb_en & wb_addr==r, wb_data (bypass).
//    Else rf_q slice r. A write to x0 is never forwarded. x0 always reads 0,
//    whatever rf_q slice 0 holds.
//  - Drain: out_valid & out_ready & !accept clears out_valid on the edge.
//    Data regs keep their last value.
//  - Accept and drain in the same cycle: the new entry replaces the old one.
//    out_valid stays 1, with no bubble.
//  - Hold: out_valid & !out_ready & wb_en & wb_addr!=0. Each held operand
//    whose stored index == wb_addr loads wb_data on that edge, so a stalled
//    operand never goes stale.
//  - flush=1 has priority. On the edge out_valid->0 and no accept happens,
//    even when in_valid & in_ready. Data regs are don't-care after flush.
//  - The stage keeps no state beyond one entry. Throughput is 1 per cycle
//    when out_ready=1.
//  - Widths: indices compare at ADDR_WIDTH. No arithmetic on data.
// TESTING
//  - Reset: rst=0 mid-entry -> out_valid=0, out_rs1=out_rs2=out_pc=0
//    right away, before the clock edge.
//  - Plain read: x5=32'h1234, x6=32'hBEEF in rf_q; in rs1=5, rs2=6, pc=0x100,
//    out_ready=1 -> next cycle out_rs1=0x1234, out_rs2=0xBEEF, out_pc=0x100.
//  - x0 and bypass: rs1=0 with rf_q slice 0=32'hFFFF_FFFF -> out_rs1=0.
//    rs2=7 with wb_en=1, wb_addr=7, wb_data=0xA5A5 -> out_rs2=0xA5A5.
//    wb_addr=0 with rs=0 -> still 0.
//  - Stall refresh: entry rs1=9 held with out_ready=0; wb x9=0x55 ->
//    out_rs1=0x55 next cycle. in_ready stays 0 and in_valid is not accepted.
//  - Back-to-back: 4 entries with in_valid=1 and out_ready=1 every cycle ->
//    4 consecutive out_valid cycles, in order. Then out_ready=0 for 2 cycles ->
//    data and out_pc stable, in_ready=0.
//  - Flush: held entry plus in_valid=1 and flush=1 -> out_valid=0 next cycle,
//    the incoming entry is never presented.

Source files
------------

// File: rtl/rf_read_stage.sv
// Register-file read stage: picks rs1/rs2 operands (with write-back bypass),
// holds one entry for execute and keeps it coherent with write-backs while stalled.
module rf_read_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PC_WIDTH   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [(1 << ADDR_WIDTH)*DATA_WIDTH-1:0]   rf_q,
    input  logic                                      wb_en,
    input  logic [ADDR_WIDTH-1:0]                     wb_addr,
    input  logic [DATA_WIDTH-1:0]                     wb_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ADDR_WIDTH-1:0]                     in_rs1,
    input  logic [ADDR_WIDTH-1:0]                     in_rs2,
    input  logic [PC_WIDTH-1:0]                       in_pc,
    input  logic                                      flush,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_WIDTH-1:0]                     out_rs1,
    output logic [DATA_WIDTH-1:0]                     out_rs2,
    output logic [PC_WIDTH-1:0]                       out_pc
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_arr [NUM_REGS];

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;

    logic                  accept_c;
    logic                  hold_wb_c;
    logic [DATA_WIDTH-1:0] sel1_c, sel2_c;

    // x0 reads zero; otherwise a same-cycle write-back wins over the file output
    function automatic logic [DATA_WIDTH-1:0] sel_operand(
        input logic [ADDR_WIDTH-1:0] r,
        input logic [DATA_WIDTH-1:0] file_val,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH-1:0] v;
        if (r == '0)
            v = '0;
        else if (we && (wa == r))
            v = wd;
        else
            v = file_val;
        return v;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
            rf_arr[i] = rf_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_ready  = !valid_q || out_ready;
    assign accept_c  = in_valid && in_ready && !flush;
    assign hold_wb_c = valid_q && !out_ready && wb_en && (wb_addr != '0);

    assign sel1_c = sel_operand(in_rs1, rf_arr[in_rs1], wb_en, wb_addr, wb_data);
    assign sel2_c = sel_operand(in_rs2, rf_arr[in_rs2], wb_en, wb_addr, wb_data);

    // Next entry: flush beats accept, accept beats drain, stall refreshes operands
    always_comb begin
        valid_d = valid_q;
        idx1_d  = idx1_q;
        idx2_d  = idx2_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d = 1'b1;
            idx1_d  = in_rs1;
            idx2_d  = in_rs2;
            op1_d   = sel1_c;
            op2_d   = sel2_c;
            pc_d    = in_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (hold_wb_c) begin
            if (idx1_q == wb_addr) op1_d = wb_data;
            if (idx2_q == wb_addr) op2_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            idx1_q  <= idx1_d;
            idx2_q  <= idx2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_rs1   = op1_q;
    assign out_rs2   = op2_q;
    assign out_pc    = pc_q;

endmodule

// File: tb/tb_rf_read_stage.sv
// Bench for rf_read_stage: directed scenarios plus random traffic against an
// entry-level behavioural model of the stage and an array model of the file.
module tb_rf_read_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 32;
    localparam int unsigned NR = 32;

    logic              clk;
    logic              rst;
    logic [NR*DW-1:0]  rf_q;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rs1, in_rs2;
    logic [PW-1:0]     in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_rs1, out_rs2;
    logic [PW-1:0]     out_pc;

    logic [DW-1:0] regs [NR];

    typedef struct {
        logic          valid;
        logic [AW-1:0] i1;
        logic [AW-1:0] i2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t m;
    int   n_checks = 0;
    int   n_fail   = 0;

    rf_read_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .rf_q(rf_q),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++)
            rf_q[i*DW +: DW] = regs[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a register read should return given the current file and write-back
    function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_en && wb_addr == r) return wb_data;
        return regs[r];
    endfunction

    // Entry after one clock, from the stage's rules
    function automatic ent_t next_entry(input ent_t cur);
        ent_t n;
        logic can_take;
        n = cur;
        can_take = !cur.valid || out_ready;
        if (flush) begin
            n.valid = 1'b0;
        end else if (in_valid && can_take) begin
            n.valid = 1'b1;
            n.i1 = in_rs1;
            n.i2 = in_rs2;
            n.d1 = read_reg(in_rs1);
            n.d2 = read_reg(in_rs2);
            n.pc = in_pc;
        end else if (cur.valid && out_ready) begin
            n.valid = 1'b0;
        end else if (cur.valid && wb_en && wb_addr != 0) begin
            if (cur.i1 == wb_addr) n.d1 = wb_data;
            if (cur.i2 == wb_addr) n.d2 = wb_data;
        end
        return n;
    endfunction

    task automatic cycle();
        ent_t nx;
        if (rst) nx = next_entry(m);
        else     nx = '{default: '0};
        @(posedge clk);
        m = nx;
        #1;
        if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", 32'(in_ready), 32'(!m.valid || out_ready));
            check("out_valid", 32'(out_valid), 32'(m.valid));
            if (m.valid) begin
                check("out_rs1", out_rs1, m.d1);
                check("out_rs2", out_rs2, m.d2);
                check("out_pc", out_pc, m.pc);
            end
        end
    end

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        m = '{default: '0};
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        regs[0] = 32'hFFFF_FFFF;

        #2;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_pc", out_pc, 32'h0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // Plain read
        regs[5] = 32'h1234; regs[6] = 32'hBEEF;
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_pc = 32'h100;
        cycle();
        check("plain_valid", 32'(out_valid), 32'h1);
        check("plain_rs1", out_rs1, 32'h1234);
        check("plain_rs2", out_rs2, 32'hBEEF);
        check("plain_pc", out_pc, 32'h100);

        // x0 ignores file contents, rs2 takes the bypass
        in_rs1 = 5'd0; in_rs2 = 5'd7; in_pc = 32'h104;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5;
        cycle();
        check("x0_rs1", out_rs1, 32'h0);
        check("bypass_rs2", out_rs2, 32'hA5A5);
        in_rs2 = 5'd0; wb_addr = 5'd0; wb_data = 32'h1234_5678; in_pc = 32'h108;
        cycle();
        check("x0_wb_rs1", out_rs1, 32'h0);
        check("x0_wb_rs2", out_rs2, 32'h0);

        // Stall refresh
        wb_en = 1'b0; in_rs1 = 5'd9; in_rs2 = 5'd3; in_pc = 32'h200;
        regs[9] = 32'h1111;
        cycle();
        check("stall_pre_rs1", out_rs1, 32'h1111);
        out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 5'd1; in_pc = 32'h300;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'h0);
        cycle();
        check("stall_rs1", out_rs1, 32'h55);
        check("stall_pc", out_pc, 32'h200);
        wb_en = 1'b0;
        cycle();
        check("stall_pc_hold", out_pc, 32'h200);

        // Back-to-back, then a two-cycle stall
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_rs1 = 5'(i + 1); in_rs2 = 5'(i + 10);
            in_pc = 32'h400 + 32'(i);
            cycle();
            check("b2b_valid", 32'(out_valid), 32'h1);
            check("b2b_pc", out_pc, 32'h400 + 32'(i));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("b2b_stall_pc", out_pc, 32'h403);
            check("b2b_stall_rdy", 32'(in_ready), 32'h0);
        end

        // Flush beats an acceptable incoming entry
        out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1; in_pc = 32'h500;
        cycle();
        check("flush_valid", 32'(out_valid), 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        check("flush_no_entry", 32'(out_valid), 32'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            wb_en     = ($urandom % 2) == 1;
            wb_addr   = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            in_rs1    = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            in_rs2    = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            in_pc     = $urandom;
            cycle();
        end

        // Async reset while an entry is held
        idle_inputs();
        out_ready = 1'b1; in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_pc = 32'h700;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        m = '{default: '0};
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_rs1", out_rs1, 32'h0);
        check("async_rst_rs2", out_rs2, 32'h0);
        check("async_rst_pc", out_pc, 32'h0);
        cycle();
        rst = 1'b1;
        cycle();
        check("post_rst_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
